// File: rtl/tl_a_arb2.sv
// 2:1 TileLink-UL A-channel arbiter with round-robin fairness and burst locking.
// D responses are steered back to the requesting master by source bit 2.
module tl_a_arb2 #(
  parameter int unsigned MAX_SIZE  = 6,
  parameter int unsigned BEAT_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  input  logic [2:0]  m0_a_opcode,
  input  logic [2:0]  m0_a_param,
  input  logic [2:0]  m0_a_size,
  input  logic [1:0]  m0_a_source,
  input  logic [31:0] m0_a_address,
  input  logic [7:0]  m0_a_mask,
  input  logic [63:0] m0_a_data,
  output logic        m0_d_valid,
  input  logic        m0_d_ready,
  output logic [2:0]  m0_d_opcode,
  output logic [2:0]  m0_d_size,
  output logic [1:0]  m0_d_source,
  output logic        m0_d_denied,
  output logic [63:0] m0_d_data,

  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  input  logic [2:0]  m1_a_opcode,
  input  logic [2:0]  m1_a_param,
  input  logic [2:0]  m1_a_size,
  input  logic [1:0]  m1_a_source,
  input  logic [31:0] m1_a_address,
  input  logic [7:0]  m1_a_mask,
  input  logic [63:0] m1_a_data,
  output logic        m1_d_valid,
  input  logic        m1_d_ready,
  output logic [2:0]  m1_d_opcode,
  output logic [2:0]  m1_d_size,
  output logic [1:0]  m1_d_source,
  output logic        m1_d_denied,
  output logic [63:0] m1_d_data,

  output logic        s_a_valid,
  input  logic        s_a_ready,
  output logic [2:0]  s_a_opcode,
  output logic [2:0]  s_a_param,
  output logic [2:0]  s_a_size,
  output logic [2:0]  s_a_source,
  output logic [31:0] s_a_address,
  output logic [7:0]  s_a_mask,
  output logic [63:0] s_a_data,
  input  logic        s_d_valid,
  output logic        s_d_ready,
  input  logic [2:0]  s_d_opcode,
  input  logic [2:0]  s_d_size,
  input  logic [2:0]  s_d_source,
  input  logic        s_d_denied,
  input  logic [63:0] s_d_data
);

  localparam logic [2:0] MAX_SZ  = 3'(MAX_SIZE);
  localparam logic [2:0] BEAT_SZ = 3'(BEAT_LOG2);

  logic       prio_q, prio_d;
  logic       lock_q, lock_d;
  logic       owner_q, owner_d;
  logic       hold_q, hold_d;
  logic [2:0] beats_left_q, beats_left_d;

  logic       grant;
  logic       a_fire;
  logic       last_beat;
  logic [2:0] eff_size;
  logic [2:0] span;
  logic [2:0] beats_m1;

  // An outstanding offer or an open burst pins the grant to the current owner.
  always_comb begin
    grant = prio_q;
    if (lock_q || hold_q) begin
      grant = owner_q;
    end else if (m0_a_valid ^ m1_a_valid) begin
      grant = m1_a_valid;
    end
  end

  always_comb begin
    if (grant) begin
      s_a_valid   = m1_a_valid;
      s_a_opcode  = m1_a_opcode;
      s_a_param   = m1_a_param;
      s_a_size    = m1_a_size;
      s_a_source  = {1'b1, m1_a_source};
      s_a_address = m1_a_address;
      s_a_mask    = m1_a_mask;
      s_a_data    = m1_a_data;
    end else begin
      s_a_valid   = m0_a_valid;
      s_a_opcode  = m0_a_opcode;
      s_a_param   = m0_a_param;
      s_a_size    = m0_a_size;
      s_a_source  = {1'b0, m0_a_source};
      s_a_address = m0_a_address;
      s_a_mask    = m0_a_mask;
      s_a_data    = m0_a_data;
    end
  end

  assign m0_a_ready = ~grant & s_a_ready;
  assign m1_a_ready = grant & s_a_ready;
  assign a_fire     = s_a_valid & s_a_ready;

  // Remaining beats after the first: only Puts wider than one beat span several.
  always_comb begin
    eff_size = (s_a_size > MAX_SZ) ? MAX_SZ : s_a_size;
    span     = eff_size - BEAT_SZ;
    if (span > 3'd3) begin
      span = 3'd3;
    end
    beats_m1 = 3'd0;
    if (!s_a_opcode[2] && (eff_size > BEAT_SZ)) begin
      beats_m1 = 3'((4'd1 << span) - 4'd1);
    end
  end

  always_comb begin
    prio_d       = prio_q;
    lock_d       = lock_q;
    beats_left_d = beats_left_q;
    last_beat    = 1'b0;
    hold_d       = s_a_valid & ~s_a_ready;
    owner_d      = grant;
    if (a_fire) begin
      if (lock_q) begin
        beats_left_d = beats_left_q - 3'd1;
        if (beats_left_q == 3'd1) begin
          lock_d    = 1'b0;
          last_beat = 1'b1;
        end
      end else if (beats_m1 != 3'd0) begin
        lock_d       = 1'b1;
        beats_left_d = beats_m1;
      end else begin
        last_beat = 1'b1;
      end
    end
    // Hand the tie-break to the other master once a message completes.
    if (last_beat) begin
      prio_d = ~grant;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q       <= 1'b0;
      lock_q       <= 1'b0;
      owner_q      <= 1'b0;
      hold_q       <= 1'b0;
      beats_left_q <= 3'd0;
    end else begin
      prio_q       <= prio_d;
      lock_q       <= lock_d;
      owner_q      <= owner_d;
      hold_q       <= hold_d;
      beats_left_q <= beats_left_d;
    end
  end

  // Stateless D return path: fields broadcast, valid steered by the tag bit.
  assign m0_d_valid  = s_d_valid & ~s_d_source[2];
  assign m1_d_valid  = s_d_valid & s_d_source[2];
  assign s_d_ready   = s_d_source[2] ? m1_d_ready : m0_d_ready;

  assign m0_d_opcode = s_d_opcode;
  assign m0_d_size   = s_d_size;
  assign m0_d_source = s_d_source[1:0];
  assign m0_d_denied = s_d_denied;
  assign m0_d_data   = s_d_data;

  assign m1_d_opcode = s_d_opcode;
  assign m1_d_size   = s_d_size;
  assign m1_d_source = s_d_source[1:0];
  assign m1_d_denied = s_d_denied;
  assign m1_d_data   = s_d_data;

endmodule

// File: tb/tb_tl_a_arb2.sv
// Scoreboard bench for tl_a_arb2: expected A beats are queued as stimulus is
// driven and popped when the slave port fires; D routing is checked inline.
module tb_tl_a_arb2;

  localparam logic [2:0] OP_PUTF = 3'd0;
  localparam logic [2:0] OP_PUTP = 3'd1;
  localparam logic [2:0] OP_GET  = 3'd4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
  logic [2:0]  m0_a_opcode, m0_a_param, m0_a_size, m1_a_opcode, m1_a_param, m1_a_size;
  logic [1:0]  m0_a_source, m1_a_source;
  logic [31:0] m0_a_address, m1_a_address;
  logic [7:0]  m0_a_mask, m1_a_mask;
  logic [63:0] m0_a_data, m1_a_data;
  logic        m0_d_valid, m0_d_ready, m1_d_valid, m1_d_ready;
  logic [2:0]  m0_d_opcode, m0_d_size, m1_d_opcode, m1_d_size;
  logic [1:0]  m0_d_source, m1_d_source;
  logic        m0_d_denied, m1_d_denied;
  logic [63:0] m0_d_data, m1_d_data;
  logic        s_a_valid, s_a_ready;
  logic [2:0]  s_a_opcode, s_a_param, s_a_size, s_a_source;
  logic [31:0] s_a_address;
  logic [7:0]  s_a_mask;
  logic [63:0] s_a_data;
  logic        s_d_valid, s_d_ready;
  logic [2:0]  s_d_opcode, s_d_size, s_d_source;
  logic        s_d_denied;
  logic [63:0] s_d_data;

  typedef struct packed {
    logic [2:0]  src;
    logic [2:0]  op;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
  } a_exp_t;

  a_exp_t sb[$];
  int total = 0;
  int passed = 0;

  tl_a_arb2 dut (
    .clock(clock), .reset_n(reset_n),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
    .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
    .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
    .m0_d_size(m0_d_size), .m0_d_source(m0_d_source), .m0_d_denied(m0_d_denied),
    .m0_d_data(m0_d_data),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
    .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
    .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
    .m1_d_size(m1_d_size), .m1_d_source(m1_d_source), .m1_d_denied(m1_d_denied),
    .m1_d_data(m1_d_data),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_size(s_d_size), .s_d_source(s_d_source), .s_d_denied(s_d_denied),
    .s_d_data(s_d_data)
  );

  always #5 clock = ~clock;

  task automatic idle_inputs();
    m0_a_valid = 1'b0; m0_a_opcode = OP_GET; m0_a_param = 3'd0; m0_a_size = 3'd3;
    m0_a_source = 2'd0; m0_a_address = 32'h0; m0_a_mask = 8'h0F; m0_a_data = 64'h0;
    m1_a_valid = 1'b0; m1_a_opcode = OP_GET; m1_a_param = 3'd0; m1_a_size = 3'd3;
    m1_a_source = 2'd0; m1_a_address = 32'h0; m1_a_mask = 8'hF0; m1_a_data = 64'h0;
    s_a_ready = 1'b0; m0_d_ready = 1'b0; m1_d_ready = 1'b0;
    s_d_valid = 1'b0; s_d_opcode = 3'd0; s_d_size = 3'd0; s_d_source = 3'd0;
    s_d_denied = 1'b0; s_d_data = 64'h0;
  endtask

  task automatic drive_m(input logic n, input logic v, input logic [2:0] op,
                         input logic [2:0] sz, input logic [1:0] src,
                         input logic [31:0] addr, input logic [63:0] data);
    if (!n) begin
      m0_a_valid = v; m0_a_opcode = op; m0_a_size = sz; m0_a_source = src;
      m0_a_address = addr; m0_a_data = data; m0_a_mask = 8'h0F; m0_a_param = 3'd0;
    end else begin
      m1_a_valid = v; m1_a_opcode = op; m1_a_size = sz; m1_a_source = src;
      m1_a_address = addr; m1_a_data = data; m1_a_mask = 8'hF0; m1_a_param = 3'd0;
    end
  endtask

  function automatic a_exp_t mk(input logic mi, input logic [2:0] op, input logic [2:0] sz,
                                input logic [1:0] src, input logic [31:0] addr,
                                input logic [63:0] data);
    a_exp_t r;
    r.src = {mi, src}; r.op = op; r.size = sz; r.addr = addr;
    r.mask = mi ? 8'hF0 : 8'h0F; r.data = data;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b0;
    m0_d_ready = 1'b1;
    #1;
    total++;
    if ({s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid} !== 5'b0)
      $display("FAIL reset_valids: got %b required 00000",
               {s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid});
    else passed++;
    total++;
    if (s_d_ready !== 1'b1) $display("FAIL reset_d_ready: got %b required 1", s_d_ready);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    s_a_ready = 1'b1;
    #1;
    total++;
    if ({s_a_valid, m0_a_ready, m1_a_ready} !== 3'b010)
      $display("FAIL reset_release: got %b required 010", {s_a_valid, m0_a_ready, m1_a_ready});
    else passed++;
    idle_inputs();
  endtask

  task automatic test_single_get();
    a_exp_t e;
    do_reset();
    @(negedge clock);
    drive_m(1'b0, 1'b1, OP_GET, 3'd3, 2'd2, 32'h8000_0000, 64'h0);
    s_a_ready = 1'b1;
    sb.push_back(mk(1'b0, OP_GET, 3'd3, 2'd2, 32'h8000_0000, 64'h0));
    #1;
    total++;
    if ({s_a_valid, s_a_source, m1_a_ready} !== 5'b1_010_0)
      $display("FAIL single_get_offer: got %b required 10100", {s_a_valid, s_a_source, m1_a_ready});
    else passed++;
    if (s_a_valid && s_a_ready) begin
      total++;
      if (sb.size() == 0) $display("FAIL single_get_sb: fire src=%h, required no fire", s_a_source);
      else begin
        e = sb.pop_front();
        if ({s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data} !== e)
          $display("FAIL single_get_sb: got %h required %h",
                   {s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data}, e);
        else passed++;
      end
    end
    // Priority now with master 1, so a tie must go its way.
    @(negedge clock);
    drive_m(1'b0, 1'b1, OP_GET, 3'd3, 2'd0, 32'h10, 64'h0);
    drive_m(1'b1, 1'b1, OP_GET, 3'd3, 2'd1, 32'h20, 64'h0);
    sb.push_back(mk(1'b1, OP_GET, 3'd3, 2'd1, 32'h20, 64'h0));
    #1;
    if (s_a_valid && s_a_ready) begin
      total++;
      if (sb.size() == 0) $display("FAIL single_get_tie_sb: fire src=%h, required no fire", s_a_source);
      else begin
        e = sb.pop_front();
        if ({s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data} !== e)
          $display("FAIL single_get_tie_sb: got %h required %h",
                   {s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data}, e);
        else passed++;
      end
    end
    @(negedge clock);
    idle_inputs();
    total++;
    if (sb.size() != 0) begin
      $display("FAIL single_get_drain: got %0d pending required 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  task automatic test_alternate();
    a_exp_t e;
    logic exp_m;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      s_a_ready = 1'b1;
      drive_m(1'b0, 1'b1, OP_GET, 3'd6, 2'd1, 32'h100 + 32'(i), 64'h0);
      drive_m(1'b1, 1'b1, OP_GET, 3'd6, 2'd2, 32'h200 + 32'(i), 64'h0);
      exp_m = 1'(i % 2);
      if (exp_m) sb.push_back(mk(1'b1, OP_GET, 3'd6, 2'd2, 32'h200 + 32'(i), 64'h0));
      else       sb.push_back(mk(1'b0, OP_GET, 3'd6, 2'd1, 32'h100 + 32'(i), 64'h0));
      #1;
      total++;
      if (s_a_source[2] !== exp_m)
        $display("FAIL alternate_grant[%0d]: got %b required %b", i, s_a_source[2], exp_m);
      else passed++;
      if (s_a_valid && s_a_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL alternate_sb: fire src=%h, required no fire", s_a_source);
        else begin
          e = sb.pop_front();
          if ({s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data} !== e)
            $display("FAIL alternate_sb[%0d]: got %h required %h", i,
                     {s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data}, e);
          else passed++;
        end
      end
    end
    @(negedge clock);
    idle_inputs();
    total++;
    if (sb.size() != 0) begin
      $display("FAIL alternate_drain: got %0d pending required 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  // Owner starts a Put burst alone; the other master requests from the second beat.
  task automatic test_burst(input logic owner, input logic [2:0] op, input logic [2:0] sz,
                            input int nbeats);
    a_exp_t e;
    logic other;
    other = ~owner;
    do_reset();
    for (int i = 0; i <= nbeats; i++) begin
      @(negedge clock);
      s_a_ready = 1'b1;
      if (i < nbeats) begin
        drive_m(owner, 1'b1, op, sz, 2'd3, 32'h1000, 64'hA000 + 64'(i));
        sb.push_back(mk(owner, op, sz, 2'd3, 32'h1000, 64'hA000 + 64'(i)));
      end else begin
        drive_m(owner, 1'b1, OP_GET, 3'd3, 2'd3, 32'h1100, 64'h0);
        sb.push_back(mk(other, OP_GET, 3'd3, 2'd0, 32'h3000, 64'h0));
      end
      if (i >= 1) drive_m(other, 1'b1, OP_GET, 3'd3, 2'd0, 32'h3000, 64'h0);
      #1;
      if (i < nbeats) begin
        total++;
        if ((other ? m1_a_ready : m0_a_ready) !== 1'b0)
          $display("FAIL burst_other_ready[%0d]: got 1 required 0", i);
        else passed++;
      end
      if (s_a_valid && s_a_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL burst_sb: fire src=%h, required no fire", s_a_source);
        else begin
          e = sb.pop_front();
          if ({s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data} !== e)
            $display("FAIL burst_sb[%0d]: got %h required %h", i,
                     {s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data}, e);
          else passed++;
        end
      end
    end
    @(negedge clock);
    idle_inputs();
    total++;
    if (sb.size() != 0) begin
      $display("FAIL burst_drain: got %0d pending required 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  task automatic test_hold();
    a_exp_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      s_a_ready = (i >= 4);
      drive_m(1'b1, (i <= 4), OP_GET, 3'd3, 2'd1, 32'h2000, 64'h0);
      if (i >= 3) drive_m(1'b0, 1'b1, OP_GET, 3'd3, 2'd0, 32'h4000, 64'h0);
      if (i == 4) sb.push_back(mk(1'b1, OP_GET, 3'd3, 2'd1, 32'h2000, 64'h0));
      if (i == 5) sb.push_back(mk(1'b0, OP_GET, 3'd3, 2'd0, 32'h4000, 64'h0));
      #1;
      if (i <= 4) begin
        total++;
        if ({s_a_valid, s_a_source, s_a_address} !== {1'b1, 3'b101, 32'h2000})
          $display("FAIL hold_offer[%0d]: got %h required %h", i,
                   {s_a_valid, s_a_source, s_a_address}, {1'b1, 3'b101, 32'h2000});
        else passed++;
      end
      if (s_a_valid && s_a_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL hold_sb: fire src=%h, required no fire", s_a_source);
        else begin
          e = sb.pop_front();
          if ({s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data} !== e)
            $display("FAIL hold_sb[%0d]: got %h required %h", i,
                     {s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data}, e);
          else passed++;
        end
      end
    end
    @(negedge clock);
    idle_inputs();
    total++;
    if (sb.size() != 0) begin
      $display("FAIL hold_drain: got %0d pending required 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  task automatic test_d_route();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      s_d_valid = 1'b1; s_d_source = 3'b101; s_d_opcode = 3'd1; s_d_size = 3'd3;
      s_d_denied = 1'b0; s_d_data = 64'hDEAD_BEEF_0123_4567;
      m0_d_ready = 1'b1; m1_d_ready = (i == 2);
      #1;
      total++;
      if ({m1_d_valid, m0_d_valid, m1_d_source, s_d_ready} !== {1'b1, 1'b0, 2'b01, (i == 2)})
        $display("FAIL d_route_m1[%0d]: got %b required %b", i,
                 {m1_d_valid, m0_d_valid, m1_d_source, s_d_ready}, {1'b1, 1'b0, 2'b01, (i == 2)});
      else passed++;
      total++;
      if ({m1_d_opcode, m1_d_size, m1_d_data} !== {3'd1, 3'd3, 64'hDEAD_BEEF_0123_4567})
        $display("FAIL d_fields_m1[%0d]: got %h required %h", i,
                 {m1_d_opcode, m1_d_size, m1_d_data}, {3'd1, 3'd3, 64'hDEAD_BEEF_0123_4567});
      else passed++;
    end
    @(negedge clock);
    s_d_source = 3'b010; s_d_denied = 1'b1; m0_d_ready = 1'b1; m1_d_ready = 1'b0;
    #1;
    total++;
    if ({m0_d_valid, m1_d_valid, m0_d_source, m0_d_denied, s_d_ready} !== 6'b1_0_10_1_1)
      $display("FAIL d_route_m0: got %b required 101011",
               {m0_d_valid, m1_d_valid, m0_d_source, m0_d_denied, s_d_ready});
    else passed++;
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    a_exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i < 3) begin
        s_a_ready = 1'b1;
        drive_m(1'b1, 1'b1, OP_PUTF, 3'd6, 2'd2, 32'h5000, 64'(i));
        sb.push_back(mk(1'b1, OP_PUTF, 3'd6, 2'd2, 32'h5000, 64'(i)));
      end else if (i == 3) begin
        idle_inputs();
        reset_n = 1'b0;
      end else begin
        reset_n = 1'b1;
      end
      #1;
      if (i == 3) begin
        total++;
        if (s_a_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b required 0", s_a_valid);
        else passed++;
      end
      if (s_a_valid && s_a_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL mid_reset_sb: fire src=%h, required no fire", s_a_source);
        else begin
          e = sb.pop_front();
          if ({s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data} !== e)
            $display("FAIL mid_reset_sb[%0d]: got %h required %h", i,
                     {s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data}, e);
          else passed++;
        end
      end
    end
    // Fresh arbitration: master 0 first, then master 1 on the next tie.
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      s_a_ready = 1'b1;
      drive_m(1'b0, 1'b1, OP_GET, 3'd3, 2'd1, 32'h6000, 64'h0);
      drive_m(1'b1, 1'b1, OP_GET, 3'd3, 2'd3, 32'h7000, 64'h0);
      if (i == 0) sb.push_back(mk(1'b0, OP_GET, 3'd3, 2'd1, 32'h6000, 64'h0));
      else        sb.push_back(mk(1'b1, OP_GET, 3'd3, 2'd3, 32'h7000, 64'h0));
      #1;
      if (s_a_valid && s_a_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL post_reset_sb: fire src=%h, required no fire", s_a_source);
        else begin
          e = sb.pop_front();
          if ({s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data} !== e)
            $display("FAIL post_reset_sb[%0d]: got %h required %h", i,
                     {s_a_source, s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data}, e);
          else passed++;
        end
      end
    end
    @(negedge clock);
    idle_inputs();
    total++;
    if (sb.size() != 0) begin
      $display("FAIL mid_reset_drain: got %0d pending required 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_get();
    test_alternate();
    test_burst(1'b1, OP_PUTF, 3'd6, 8);
    test_burst(1'b0, OP_PUTF, 3'd7, 8);
    test_burst(1'b1, OP_PUTP, 3'd4, 2);
    test_hold();
    test_d_route();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
